// File: rtl/car_game_pkg.sv
// Shared types and constants for the car game datapath: lanes, colours and draw FSM states.
package car_game_pkg;

    localparam int unsigned LANE_COUNT = 3;

    typedef logic [1:0] lane_t;
    localparam lane_t LANE_MAX = lane_t'(LANE_COUNT - 1);

    typedef logic [2:0] colour_t;
    localparam colour_t TRANSPARENT = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFlush
    } state_t;

endpackage

// File: rtl/car_pixel_counter.sv
// Column/row scan counter over the car sprite, with a flag on the final pixel.
module car_pixel_counter #(
    parameter int unsigned CAR_W = 12,
    parameter int unsigned CAR_H = 16,
    parameter int unsigned COL_W = $clog2(CAR_W),
    parameter int unsigned ROW_W = $clog2(CAR_H)
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic             en,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(CAR_W - 1));
    assign row_end = (row == ROW_W'(CAR_H - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_car_draw.sv
// Player-car lane register and sprite overlay sequencer (one pixel per cycle after frame_done).
// Optional: define PLAYER_CAR_TRANSPARENT_EN to suppress plotting of black sprite pixels.
module player_car_draw
    import car_game_pkg::*;
#(
    parameter int unsigned CAR_W      = 12,
    parameter int unsigned CAR_H      = 16,
    parameter int unsigned LANE_X0    = 40,
    parameter int unsigned LANE_PITCH = 32,
    parameter int unsigned CAR_Y      = 100
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       LeftEn,
    input  logic       RightEn,
    input  logic       DriveEn,
    input  logic       frame_done,
    input  logic [2:0] sprite_colour,
    output logic [7:0] sprite_addr,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       plot,
    output logic [1:0] lane,
    output logic       busy
);

    localparam int unsigned COL_W = $clog2(CAR_W);
    localparam int unsigned ROW_W = $clog2(CAR_H);

    state_t           state;
    lane_t            draw_lane;
    logic             valid_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last;
    logic             start;

    assign start = (state == StIdle) && frame_done && DriveEn;

    car_pixel_counter #(
        .CAR_W (CAR_W),
        .CAR_H (CAR_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_counter (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .en       (state == StDraw),
        .clr      (start),
        .col      (col),
        .row      (row),
        .last     (last)
    );

    assign sprite_addr = 8'(32'(row) * CAR_W + 32'(col));
    assign busy        = (state != StIdle);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state     <= StIdle;
            lane      <= 2'd1;
            draw_lane <= '0;
            valid_d   <= 1'b0;
            oX        <= '0;
            oY        <= '0;
        end else begin
            if (DriveEn) begin
                if (LeftEn && !RightEn && lane != '0) begin
                    lane <= lane - 2'd1;
                end else if (RightEn && !LeftEn && lane != LANE_MAX) begin
                    lane <= lane + 2'd1;
                end
            end

            // Coordinates lag the address by one cycle to line up with ROM data.
            valid_d <= (state == StDraw);
            if (state == StDraw) begin
                oX <= 8'(LANE_X0 + 32'(draw_lane) * LANE_PITCH + 32'(col));
                oY <= 7'(CAR_Y + 32'(row));
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StDraw;
                        draw_lane <= lane;
                    end
                end
                StDraw: begin
                    if (last) begin
                        state <= StFlush;
                    end
                end
                StFlush: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign oColour = valid_d ? sprite_colour : TRANSPARENT;

`ifdef PLAYER_CAR_TRANSPARENT_EN
    assign plot = valid_d && (sprite_colour != TRANSPARENT);
`else
    assign plot = valid_d;
`endif

endmodule
